// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue and its FIFO.
package inst_prefetch_queue_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DISCARD
   } pf_state_t;

   localparam logic [31:0] NOP_WORD = 32'h0;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } pf_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Instruction-memory handshake, redirect and pipeline-side signals of the prefetch queue.
interface inst_prefetch_queue_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        deq;
   logic        valid;
   logic [31:0] instruction;
   logic [31:0] inst_pc;

   // master: the prefetch queue itself; slave: memory plus pipeline environment
   modport master (
      output imem_req, imem_addr, valid, instruction, inst_pc,
      input  imem_ack, imem_rdata, redirect, redirect_pc, deq
   );

   modport slave (
      input  imem_req, imem_addr, valid, instruction, inst_pc,
      output imem_ack, imem_rdata, redirect, redirect_pc, deq
   );

endinterface

// File: rtl/inst_fifo_n.sv
// Register FIFO of {instr, pc} entries with synchronous clear; head is read from storage.
module inst_fifo_n
   import inst_prefetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  pf_entry_t        push_data,
   input  logic             pop,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output pf_entry_t        head
);

   pf_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Payload needs no reset: entries are only observed when count != 0.
   always_ff @(posedge clk) begin
      if (push && !clear) mem_q[wr_ptr_q] <= push_data;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetcher with redirect flush and a small in-order queue.
// Optional PREFETCH_BYPASS_EN forwards an acked word straight to the outputs when empty.
module inst_prefetch_queue
   import inst_prefetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   inst_prefetch_queue_if.master bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   pf_state_t        state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      req_addr_q;
   logic [CNT_W-1:0] count, count_after;
   pf_entry_t        head, push_data;
   logic             ack_live, bypass, push, pop;

   // An ack only delivers usable data in WAIT and when no redirect flushes it.
   assign ack_live = (state_q == WAIT) && bus.imem_ack && !bus.redirect;

`ifdef PREFETCH_BYPASS_EN
   assign bypass = ack_live && (count == '0);
`else
   assign bypass = 1'b0;
`endif

   assign pop         = bus.deq && (count != '0) && !bus.redirect;
   assign push        = ack_live && !(bypass && bus.deq);
   assign count_after = count + CNT_W'(push) - CNT_W'(pop);

   assign push_data.instr = bus.imem_rdata;
   assign push_data.pc    = fetch_pc_q;

   inst_fifo_n #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data(push_data),
      .pop      (pop),
      .clear    (bus.redirect),
      .count    (count),
      .head     (head)
   );

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      case (state_q)
         IDLE: begin
            if (bus.redirect) begin
               fetch_pc_d = bus.redirect_pc;
            end else if (count < CNT_W'(DEPTH)) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.redirect) begin
               fetch_pc_d = bus.redirect_pc;
               state_d    = bus.imem_ack ? IDLE : DISCARD;
            end else if (bus.imem_ack) begin
               fetch_pc_d = fetch_pc_q + PC_STEP;
               state_d    = (count_after < CNT_W'(DEPTH)) ? WAIT : IDLE;
            end
         end
         DISCARD: begin
            if (bus.redirect) fetch_pc_d = bus.redirect_pc;
            if (bus.imem_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         // DISCARD keeps the old address so the abandoned request stays stable.
         if (state_d == WAIT) req_addr_q <= fetch_pc_d;
      end
   end

   assign bus.imem_req  = (state_q != IDLE);
   assign bus.imem_addr = bus.imem_req ? req_addr_q : 32'h0;

   always_comb begin
      bus.valid       = 1'b0;
      bus.instruction = NOP_WORD;
      bus.inst_pc     = NOP_WORD;
      if (count != '0) begin
         bus.valid       = 1'b1;
         bus.instruction = head.instr;
         bus.inst_pc     = head.pc;
      end else if (bypass) begin
         bus.valid       = 1'b1;
         bus.instruction = bus.imem_rdata;
         bus.inst_pc     = fetch_pc_q;
      end
   end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
Fetch-side stage between instruction memory and the IF/ID pipeline register. It issues sequential word fetches over a request/acknowledge instruction-memory handshake and buffers returned words with their PCs in a small FIFO. It presents one instruction per cycle to the pipeline. On a taken branch or jump redirect it flushes all buffered and in-flight words and resumes fetching at the target.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  32  word address of the request; stable while imem_req=1
imem_ack  input  1  request accepted; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
redirect  input  1  taken branch/jump; flush and refetch
redirect_pc  input  32  redirect target, word aligned
deq  input  1  pipeline consumes head entry this cycle
valid  output  1  head entry present
instruction  output  32  head instruction; 32'h0 when valid=0
inst_pc  output  32  PC of head instruction; 32'h0 when valid=0

Behaviour:
- Reset (reset=0, asynchronous): fetch_pc=RESET_PC, queue empty, count=0, state=IDLE, imem_req=0, valid=0, instruction=0, inst_pc=0.
- FSM states: IDLE, WAIT, DISCARD. All transitions occur on the rising edge of clk.
- IDLE -> WAIT when count < DEPTH and redirect=0. imem_req=1, imem_addr=fetch_pc.
- WAIT, imem_ack=1, redirect=0:
  - Enqueue {imem_rdata, fetch_pc}.
  - fetch_pc += 4, wrapping mod 2^32.
  - If count+1 < DEPTH (after any same-cycle deq), stay in WAIT and issue the next request back to back. Otherwise go to IDLE.
- WAIT, imem_ack=0: hold imem_req and imem_addr unchanged.
- Redirect has priority over deq and enqueue in every state.
  - Queue is cleared; count=0.
  - fetch_pc=redirect_pc.
  - In WAIT with imem_ack=0: go to DISCARD.
  - In WAIT with imem_ack=1: drop the data and go to IDLE.
  - In IDLE: stay in IDLE.
- DISCARD: imem_req stays 1 with the old address; the handshake is never abandoned.
  - On imem_ack, drop the data and go to IDLE.
  - A new redirect in DISCARD only updates fetch_pc.
- Request latency: at most one request is outstanding. The first fetch after reset release or after a redirect has imem_req high one cycle after the transition to IDLE.
- Dequeue: valid = (count != 0). deq with valid=0 is ignored.
- Same-cycle deq and enqueue: count is unchanged, and head and tail both advance.
- Full (count=DEPTH): no new request issues; the queue never overflows.
- Head outputs are driven from registered storage. Pointers are log2(DEPTH) bits and wrap naturally.
- Redirect while the queue is full with deq=1: the flush wins, and the deq is ignored.

Optional Feature:
PREFETCH_BYPASS_EN
- Defined: when count=0 and a non-discarded imem_ack arrives, valid=1, and instruction/inst_pc come combinationally from imem_rdata and fetch_pc in that cycle. If deq=1 in that cycle, the word is consumed and not enqueued. A redirect in that cycle suppresses the bypass.
- Undefined: no combinational path from imem_* to the outputs. The earliest valid is one cycle after the ack.

Decomposition:
- Shared package holds:
  - pf_state_t enum {IDLE, WAIT, DISCARD}
  - NOP_WORD = 32'h0
  - PC_STEP = 4
  - pf_entry_t {instr[31:0], pc[31:0]}
- One natural sub-module: inst_fifo_n. It is a parameterised 64-bit-wide register FIFO with push, pop, clear, count and head outputs, and the same clock and reset. The FSM and fetch_pc stay in inst_prefetch_queue.

Test Plan:
- Reset, then release with imem_ack tied high -> imem_addr sequence 0,4,8,12. Queue fills after 4 acks, imem_req drops, valid=1, instruction=word@0, inst_pc=0.
- deq held high with 1-cycle ack memory -> steady stream of inst_pc 0,4,8,... with no gaps after fill. count never exceeds DEPTH.
- Redirect to 32'h100 while WAIT and ack delayed 3 cycles -> state DISCARD, imem_addr held at the old address until ack. That data is never seen at the output. The next request address is 32'h100.
- Redirect coinciding with imem_ack and deq on a full queue -> count=0 and valid=0 next cycle. The acked word is dropped, and the next fetch is redirect_pc.
- Assert reset mid-WAIT -> imem_req, valid and outputs go to 0 immediately, without waiting for a clock edge. After release, the first request goes to RESET_PC.
- With PREFETCH_BYPASS_EN, empty queue, ack with rdata=32'hDEAD_BEEF and deq=1 -> valid=1 and instruction=32'hDEADBEEF in the same cycle, and count stays 0.
